// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives a registered-read IRAM,
// and hands 16-bit instructions to decode over a valid/ready handshake.
//
// Ports:
//   i_clock, i_reset       clock and synchronous active-high reset
//   i_start                pulse; begin fetching at RESET_PC from IDLE/HALT
//   o_iram_addr, i_iram_q  IRAM read address / data (data one cycle later)
//   o_instr, o_instr_pc    registered instruction and its address
//   o_instr_valid          output register holds a valid instruction
//   i_instr_ready          decode accepts (transfer = valid && ready)
//   i_redirect, i_redirect_pc  taken branch; flush and refetch from target
//   o_busy, o_halted       RUN/DRAIN and HALT status
module instr_fetch_ctrl #(
    parameter int                ADDR_W      = 8,
    parameter int                INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'b1111
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [ADDR_W-1:0]  o_iram_addr,
    input  logic [INSTR_W-1:0] i_iram_q,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_pc,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_busy,
    output logic               o_halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fpc;
    logic [ADDR_W-1:0]   r_ppc;
    logic                r_pend;
    logic [INSTR_W-1:0]  r_instr;
    logic [ADDR_W-1:0]   r_instr_pc;
    logic                r_instr_valid;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_fpc_nxt;
    logic [ADDR_W-1:0]   w_ppc_nxt;
    logic                w_pend_nxt;
    logic [INSTR_W-1:0]  w_instr_nxt;
    logic [ADDR_W-1:0]   w_instr_pc_nxt;
    logic                w_instr_valid_nxt;
    logic [ADDR_W-1:0]   w_iram_addr;

    logic                w_xfer;
    logic                w_adv;
    logic                w_redir;
    logic                w_is_halt;

    assign w_xfer    = r_instr_valid && i_instr_ready;
    // Advance unless a loaded read would land on an output decode refuses.
    assign w_adv     = !r_pend || !r_instr_valid || i_instr_ready;
    assign w_redir   = i_redirect && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_is_halt = (i_iram_q[15:12] == HALT_OPCODE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_fpc         <= RESET_PC;
            r_ppc         <= '0;
            r_pend        <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fpc         <= w_fpc_nxt;
            r_ppc         <= w_ppc_nxt;
            r_pend        <= w_pend_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_fpc_nxt         = r_fpc;
        w_ppc_nxt         = r_ppc;
        w_pend_nxt        = r_pend;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_iram_addr       = r_fpc;

        if (w_redir) begin
            // Issue the target now; the in-flight read and any held
            // instruction (including a draining halt) are dropped.
            w_iram_addr       = i_redirect_pc;
            w_ppc_nxt         = i_redirect_pc;
            w_fpc_nxt         = i_redirect_pc + 1'b1;
            w_pend_nxt        = 1'b1;
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = S_RUN;
        end else begin
            unique case (r_state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        w_state_nxt = S_RUN;
                        w_fpc_nxt   = RESET_PC;
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        w_iram_addr = r_fpc;
                        w_ppc_nxt   = r_fpc;
                        w_fpc_nxt   = r_fpc + 1'b1;
                        w_pend_nxt  = 1'b1;
                        if (r_pend) begin
                            w_instr_nxt       = i_iram_q;
                            w_instr_pc_nxt    = r_ppc;
                            w_instr_valid_nxt = 1'b1;
                            if (w_is_halt) begin
                                // Discard the read issued alongside the halt.
                                w_pend_nxt  = 1'b0;
                                w_fpc_nxt   = r_fpc;
                                w_state_nxt = S_DRAIN;
                            end
                        end else if (w_xfer) begin
                            w_instr_valid_nxt = 1'b0;
                        end
                    end else begin
                        // Re-present the pending address so iram_q stays put.
                        w_iram_addr = r_ppc;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        w_instr_valid_nxt = 1'b0;
                        w_state_nxt       = S_HALT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_iram_addr   = w_iram_addr;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_halted      = (r_state == S_HALT);

endmodule
